// File: rtl/frame_strobe_sequencer.sv
// Column configuration-write sequencer: setup / one-hot strobe / hold around each frame word.
// Optional even-parity command check is compiled in with `define FRAME_PARITY_EN.
module frame_strobe_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int FrameIdxWidth   = 5,
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 1,
  parameter int HOLD_CYCLES     = 1
) (
  input  logic                       UserCLK,
  input  logic                       Reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [FrameIdxWidth-1:0]   cmd_frame,
  input  logic [FrameBitsPerRow-1:0] cmd_data,
`ifdef FRAME_PARITY_EN
  input  logic                       cmd_parity,
  output logic                       err_parity,
`endif
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       err_addr,
  input  logic                       err_clear
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

  logic [1:0]                 state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [FrameIdxWidth-1:0]   idx_q, idx_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d, onehot;
  logic                       done_q, done_d;
  logic                       err_addr_q, err_addr_d;
  logic                       accept, addr_bad, parity_bad, cmd_ok;

  assign cmd_ready = (state_q == S_IDLE) & ~Reset;
  assign accept    = cmd_valid & cmd_ready;
  assign addr_bad  = 32'(cmd_frame) >= 32'(MaxFramesPerCol);

`ifdef FRAME_PARITY_EN
  logic err_parity_q, err_parity_d;
  // Even parity: cmd_parity must equal the XOR of all data bits.
  assign parity_bad   = cmd_parity != (^cmd_data);
  assign err_parity_d = (accept & parity_bad) | (err_parity_q & ~err_clear);
  assign err_parity   = err_parity_q;

  always_ff @(posedge UserCLK) begin
    if (Reset) err_parity_q <= 1'b0;
    else       err_parity_q <= err_parity_d;
  end
`else
  assign parity_bad = 1'b0;
`endif

  assign cmd_ok = ~addr_bad & ~parity_bad;

  // Decoded strobe for the latched index; idx_q is always in range once latched.
  for (genvar gi = 0; gi < MaxFramesPerCol; gi++) begin : g_onehot
    assign onehot[gi] = (idx_q == FrameIdxWidth'(gi));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    strobe_d   = strobe_q;
    done_d     = 1'b0;
    err_addr_d = (accept & addr_bad) | (err_addr_q & ~err_clear);
    case (state_q)
      S_IDLE: begin
        if (accept && cmd_ok) begin
          data_d  = cmd_data;
          idx_d   = cmd_frame;
          cnt_d   = SETUP_LOAD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          strobe_d = onehot;
          cnt_d    = STROBE_LOAD;
          state_d  = S_STROBE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 8'd0) begin
          strobe_d = '0;
          cnt_d    = HOLD_LOAD;
          state_d  = S_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        strobe_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= '0;
      data_q     <= '0;
      strobe_q   <= '0;
      done_q     <= 1'b0;
      err_addr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Bench for frame_strobe_sequencer: one default instance and one with 2/3/2 timing,
// checked every cycle against a timeline model (elapsed cycles since accept).
module tb_frame_strobe_sequencer;

  localparam int NF = 20;
  localparam int W  = 32;
  localparam int IW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                err_clear;
  logic                valid     [2];
  logic [IW-1:0]       frame     [2];
  logic [W-1:0]        data      [2];
  logic                ready     [2];
  logic                busy      [2];
  logic                done      [2];
  logic                err_addr  [2];
  logic [W-1:0]        fdata     [2];
  logic [NF-1:0]       fstb      [2];
`ifdef FRAME_PARITY_EN
  logic                par       [2];
  logic                err_par   [2];
`endif

  frame_strobe_sequencer dut_a (
    .UserCLK(clk), .Reset(rst), .cmd_valid(valid[0]), .cmd_ready(ready[0]),
    .cmd_frame(frame[0]), .cmd_data(data[0]),
`ifdef FRAME_PARITY_EN
    .cmd_parity(par[0]), .err_parity(err_par[0]),
`endif
    .FrameData(fdata[0]), .FrameStrobe(fstb[0]), .busy(busy[0]), .done(done[0]),
    .err_addr(err_addr[0]), .err_clear(err_clear)
  );

  frame_strobe_sequencer #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut_b (
    .UserCLK(clk), .Reset(rst), .cmd_valid(valid[1]), .cmd_ready(ready[1]),
    .cmd_frame(frame[1]), .cmd_data(data[1]),
`ifdef FRAME_PARITY_EN
    .cmd_parity(par[1]), .err_parity(err_par[1]),
`endif
    .FrameData(fdata[1]), .FrameStrobe(fstb[1]), .busy(busy[1]), .done(done[1]),
    .err_addr(err_addr[1]), .err_clear(err_clear)
  );

  // Reference model: a write is described only by the edge it was accepted on.
  int        SC [2] = '{1, 2};
  int        TC [2] = '{1, 3};
  int        HC [2] = '{1, 2};
  int        m_start [2];
  int        m_frame [2];
  logic [W-1:0] m_data [2];
  bit        m_err  [2];
  bit        m_perr [2];
  bit        acc    [2];
  int        cyc;
  int        n_cmp;
  int        n_bad;

  task automatic model_edge();
    int  len;
    bit  rdy, bad_addr, bad_par;
    for (int i = 0; i < 2; i++) begin
      len      = SC[i] + TC[i] + HC[i];
      rdy      = ((cyc - m_start[i]) >= len) && !rst;
      bad_addr = int'(frame[i]) >= NF;
      bad_par  = 1'b0;
`ifdef FRAME_PARITY_EN
      bad_par  = (par[i] != (^data[i]));
`endif
      acc[i] = 1'b0;
      if (rst) begin
        m_start[i] = -1000;
        m_data[i]  = '0;
        m_err[i]   = 1'b0;
        m_perr[i]  = 1'b0;
      end else begin
        if (valid[i] && rdy) begin
          acc[i] = 1'b1;
          $display("txn inst=%0d edge=%0d frame=%0d data=%08h addr_ok=%0d par_ok=%0d",
                   i, cyc + 1, frame[i], data[i], !bad_addr, !bad_par);
          if (!bad_addr && !bad_par) begin
            m_start[i] = cyc + 1;
            m_frame[i] = int'(frame[i]);
            m_data[i]  = data[i];
          end
        end
        m_err[i]  = (acc[i] && bad_addr) || (m_err[i] && !err_clear);
        m_perr[i] = (acc[i] && bad_par)  || (m_perr[i] && !err_clear);
      end
    end
    cyc++;
  endtask

  task automatic check(string tag, int i, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s inst=%0d edge=%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic check_all(int i);
    int e, len;
    logic [63:0] exp_stb;
    len     = SC[i] + TC[i] + HC[i];
    e       = cyc - m_start[i];
    exp_stb = (e >= SC[i] && e < SC[i] + TC[i]) ? (64'd1 << m_frame[i]) : 64'd0;
    check("cmd_ready",   i, 64'(ready[i]),    64'((e >= len) && !rst));
    check("busy",        i, 64'(busy[i]),     64'(e < len));
    check("done",        i, 64'(done[i]),     64'(e == len));
    check("FrameStrobe", i, 64'(fstb[i]),     exp_stb);
    check("FrameData",   i, 64'(fdata[i]),    64'(m_data[i]));
    check("err_addr",    i, 64'(err_addr[i]), 64'(m_err[i]));
`ifdef FRAME_PARITY_EN
    check("err_parity",  i, 64'(err_par[i]),  64'(m_perr[i]));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all(0);
    check_all(1);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_cmd(int i, int f, logic [W-1:0] d);
    frame[i] = IW'(f);
    data[i]  = d;
`ifdef FRAME_PARITY_EN
    par[i]   = ^d;
`endif
  endtask

  task automatic send(int i, int f, logic [W-1:0] d);
    set_cmd(i, f, d);
    valid[i] = 1'b1;
    step();
    valid[i] = 1'b0;
  endtask

  initial begin
    int k;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst   = 1'b1;
    err_clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid[i]   = 1'b0;
      set_cmd(i, 0, '0);
      m_start[i] = -1000;
      m_frame[i] = 0;
      m_data[i]  = '0;
      m_err[i]   = 1'b0;
      m_perr[i]  = 1'b0;
    end

    // Reset values, then release
    idle(2);
    rst = 1'b0;
    step();

    // Default timing: frame 3
    send(0, 3, 32'hDEADBEEF);
    idle(4);

    // Stretched timing: frame 19 on the 2/3/2 instance
    send(1, 19, 32'hA5A5A5A5);
    idle(8);

    // cmd_valid held high, frames 0,1,2 back-to-back
    k = 0;
    set_cmd(0, 0, $urandom);
    valid[0] = 1'b1;
    for (int c = 0; c < 20 && k < 3; c++) begin
      step();
      if (acc[0]) begin
        k++;
        set_cmd(0, k, $urandom);
      end
    end
    valid[0] = 1'b0;
    idle(4);

    // Out-of-range frame, clear, then error and clear together
    send(0, 20, 32'h12345678);
    idle(2);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    step();
    err_clear = 1'b1;
    send(0, 25, 32'h0BADF00D);
    err_clear = 1'b0;
    idle(2);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;

    // Reset while frame 5 strobe is high
    send(0, 5, 32'hCAFEF00D);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(3);

`ifdef FRAME_PARITY_EN
    // Parity mismatch is rejected, matching parity is written
    set_cmd(0, 7, 32'h00000001);
    par[0]   = 1'b0;
    valid[0] = 1'b1;
    step();
    valid[0] = 1'b0;
    idle(2);
    send(0, 7, 32'h00000001);
    idle(4);
`endif

    // Randomised traffic on both instances
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        valid[i] = 1'($urandom_range(0, 1));
        set_cmd(i, int'($urandom_range(0, 23)), $urandom);
`ifdef FRAME_PARITY_EN
        if ($urandom_range(0, 7) == 0) par[i] = ~par[i];
`endif
      end
      err_clear = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    err_clear = 1'b0;
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
